// File: rtl/qos_arbiter.sv
// qos_arbiter: weighted round-robin drain of four source FIFOs into one sink.
// Optional macro QOS_AF_PRIORITY_EN lets almost-full sources jump the queue.
module qos_arbiter #(
  parameter int WIDTH = 4,
  parameter int W0    = 4,
  parameter int W1    = 2,
  parameter int W2    = 1,
  parameter int W3    = 1
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic [3:0]         EMPTY,
  input  logic [3:0]         ALMOST_FULL,
  input  logic [4*WIDTH-1:0] DATO_IN,
  input  logic               OUT_FULL,
  output logic [3:0]         POP,
  output logic               PUSH_OUT,
  output logic [WIDTH-1:0]   DATO_OUT,
  output logic [1:0]         GRANT,
  output logic               ACTIVE
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP_ST = 2'd1,
    CAPT   = 2'd2
  } state_t;

  // A zero weight would starve a channel, so it is promoted to one.
  localparam logic [3:0] WT0 = (W0 < 1) ? 4'd1 : 4'(W0);
  localparam logic [3:0] WT1 = (W1 < 1) ? 4'd1 : 4'(W1);
  localparam logic [3:0] WT2 = (W2 < 1) ? 4'd1 : 4'(W2);
  localparam logic [3:0] WT3 = (W3 < 1) ? 4'd1 : 4'(W3);

  state_t state;
  state_t state_nx;

  logic [1:0]       ptr;
  logic [3:0]       cred;
  logic [1:0]       ptr_nx;
  logic [3:0]       cred_nx;
  logic [1:0]       sel;
  logic [3:0]       elig;
  logic             go;
  logic [1:0]       cand;
  logic [1:0]       rr_sel;
  logic             rr_found;
  logic [WIDTH-1:0] capt;

  function automatic logic [3:0] wt_of(input logic [1:0] c);
    logic [3:0] w;
    unique case (c)
      2'd0:    w = WT0;
      2'd1:    w = WT1;
      2'd2:    w = WT2;
      default: w = WT3;
    endcase
    return w;
  endfunction

  assign elig = ~EMPTY;
  assign go   = (state == IDLE) && (|elig) && !OUT_FULL;

  // First eligible channel after the pointer, the pointer itself last.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = ptr;
    cand     = ptr;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!rr_found && elig[cand]) begin
        rr_found = 1'b1;
        rr_sel   = cand;
      end
    end
  end

`ifdef QOS_AF_PRIORITY_EN
  logic [3:0] af_hit;
  logic [1:0] af_sel;

  assign af_hit = elig & ALMOST_FULL;

  // Lowest-index eligible almost-full channel.
  always_comb begin
    af_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (af_hit[i]) af_sel = 2'(i);
    end
  end
`else
  logic unused_af;
  assign unused_af = ^ALMOST_FULL;
`endif

  // Pick the next channel and the pointer/credit it leaves behind.
  always_comb begin
    sel     = ptr;
    ptr_nx  = ptr;
    cred_nx = cred;
    if (elig[ptr] && (cred != 4'd0)) begin
      sel     = ptr;
      cred_nx = cred - 4'd1;
    end else begin
      sel     = rr_sel;
      ptr_nx  = rr_sel;
      cred_nx = wt_of(rr_sel) - 4'd1;
    end
`ifdef QOS_AF_PRIORITY_EN
    if (|af_hit) begin
      sel     = af_sel;
      ptr_nx  = ptr;
      cred_nx = cred;
    end
`endif
  end

  // Read-data mux for the granted channel.
  always_comb begin
    capt = '0;
    for (int i = 0; i < 4; i++) begin
      if (GRANT == 2'(i)) capt = DATO_IN[i*WIDTH +: WIDTH];
    end
  end

  // Transfer sequencing: pop, wait for read data, push.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (go) state_nx = POP_ST;
      POP_ST:  state_nx = CAPT;
      CAPT:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  // Registered strobes, data and arbitration state.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      POP      <= 4'd0;
      PUSH_OUT <= 1'b0;
      DATO_OUT <= '0;
      GRANT    <= 2'd0;
      ACTIVE   <= 1'b0;
      ptr      <= 2'd3;
      cred     <= 4'd0;
    end else begin
      POP      <= 4'd0;
      PUSH_OUT <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            POP    <= 4'b0001 << sel;
            GRANT  <= sel;
            ACTIVE <= 1'b1;
            ptr    <= ptr_nx;
            cred   <= cred_nx;
          end
        end
        POP_ST: begin
        end
        CAPT: begin
          DATO_OUT <= capt;
          PUSH_OUT <= 1'b1;
          ACTIVE   <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
